// File: rtl/sha_1_pkg.sv
// sha_1_pkg: shared SHA-1 block/digest types, arbiter states and core timing constants.
package sha_1_pkg;
  typedef logic [15:0][31:0] block_t;
  typedef logic [4:0][31:0] digest_t;
  typedef enum logic [2:0] {FLUSH, IDLE, LOAD, WAIT, RESP} arb_state_t;
  localparam int SHA1_CORE_LATENCY = 82;
  localparam int FLUSH_CYCLES = 90;
  localparam digest_t SHA1_H_INIT = {32'hc3d2e1f0, 32'h10325476, 32'h98badcfe, 32'hefcdab89, 32'h67452301};
endpackage

// File: rtl/sha_1_rr_pick.sv
// sha_1_rr_pick: first set request searching round-robin from last_grant+1.
module sha_1_rr_pick #(
  parameter int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last_grant,
  output logic [N-1:0] grant,
  output logic [W-1:0] idx
);
  logic [W-1:0] j;
  always_comb begin
    grant = '0;
    idx = '0;
    j = '0;
    // walk from farthest to nearest so the nearest set bit is the one left standing
    for (int k = N; k >= 1; k--) begin
      j = W'((int'(last_grant) + k) % N);
      if (req[j]) begin
        grant = N'(1) << j;
        idx = j;
      end
    end
  end
endmodule

// File: rtl/sha_1_arbiter.sv
// sha_1_arbiter: round-robin sharing of one sha_1_core among NUM_REQ requesters.
// Define SHA1_ARB_TIMEOUT_EN to add a WAIT watchdog that returns an error response.
module sha_1_arbiter
  import sha_1_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT_CYCLES = 127,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req_valid,
  input  block_t             req_data [NUM_REQ],
  output logic [NUM_REQ-1:0] req_ready,
  output logic               rsp_valid,
  output logic [IW-1:0]      rsp_id,
  output digest_t            rsp_digest,
  output logic               rsp_error,
  output logic               core_enable,
  output block_t             core_data,
  input  digest_t            core_result,
  input  logic               core_done,
  output logic               busy
);
  localparam int FW = $clog2(FLUSH_CYCLES + 1);
  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("sha_1_arbiter: parameter out of range");
  end
  arb_state_t state;
  logic [FW-1:0] flush_cnt;
  logic [IW-1:0] last_grant, pick_idx;
  logic [NUM_REQ-1:0] pick_grant;
  sha_1_rr_pick #(.N(NUM_REQ)) u_pick (
    .req(req_valid),
    .last_grant(last_grant),
    .grant(pick_grant),
    .idx(pick_idx)
  );
  assign busy = state != IDLE;
`ifdef SHA1_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wait_cnt;
  logic err_q;
  assign rsp_error = err_q;
`else
  assign rsp_error = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FLUSH;
      flush_cnt <= FW'(FLUSH_CYCLES);
      last_grant <= IW'(NUM_REQ - 1);
      req_ready <= '0;
      rsp_valid <= 1'b0;
      rsp_id <= '0;
      rsp_digest <= '0;
      core_enable <= 1'b0;
      core_data <= '0;
`ifdef SHA1_ARB_TIMEOUT_EN
      wait_cnt <= '0;
      err_q <= 1'b0;
`endif
    end else begin
      req_ready <= '0;
      rsp_valid <= 1'b0;
      core_enable <= 1'b0;
      case (state)
        FLUSH: begin
          flush_cnt <= flush_cnt == '0 ? flush_cnt : flush_cnt - 1'b1;
          state <= flush_cnt == '0 ? IDLE : FLUSH;
        end
        IDLE: if (|req_valid) begin
          req_ready <= pick_grant;
          core_data <= req_data[pick_idx];
          rsp_id <= pick_idx;
          last_grant <= pick_idx;
          state <= LOAD;
        end
        LOAD: begin
          core_enable <= 1'b1;
          state <= WAIT;
`ifdef SHA1_ARB_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        WAIT: begin
          if (core_done) begin
            rsp_valid <= 1'b1;
            rsp_digest <= core_result;
            state <= RESP;
          end
`ifdef SHA1_ARB_TIMEOUT_EN
          else if (wait_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            rsp_valid <= 1'b1;
            rsp_digest <= '0;
            err_q <= 1'b1;
            state <= RESP;
          end
          wait_cnt <= wait_cnt + 1'b1;
`endif
        end
        RESP: begin
          flush_cnt <= FW'(FLUSH_CYCLES);
`ifdef SHA1_ARB_TIMEOUT_EN
          // an aborted job may still finish in the core later, so drain it
          state <= err_q ? FLUSH : IDLE;
          err_q <= 1'b0;
`else
          state <= IDLE;
`endif
        end
        default: state <= FLUSH;
      endcase
    end
  end
endmodule

// File: tb/tb_sha_1_arbiter.sv
// tb_sha_1_arbiter: randomized bench with a SHA-1 core model and a round-robin reference model.
module tb_sha_1_arbiter;
  import sha_1_pkg::*;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;
  logic [3:0] rv, hold, req_ready;
  block_t rd [4];
  logic rsp_valid, rsp_error, core_enable, core_done, busy;
  logic [1:0] rsp_id;
  digest_t rsp_digest, core_result;
  block_t core_data;
  sha_1_arbiter dut (
    .clk(clk), .reset(reset), .req_valid(rv), .req_data(rd), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_digest(rsp_digest), .rsp_error(rsp_error),
    .core_enable(core_enable), .core_data(core_data), .core_result(core_result),
    .core_done(core_done), .busy(busy)
  );
  localparam digest_t ABC = {32'h9cd0d89d, 32'h7850c26c, 32'hba3e2571, 32'h4706816a, 32'ha9993e36};
  localparam digest_t EMPTY = {32'hafd80709, 32'h95601890, 32'h3255bfef, 32'h5e6b4b0d, 32'hda39a3ee};
  int checks = 0, errors = 0, cyc = 0, since_rst = 0, nrsp = 0, inflight = -1, m_last = 3;
  int en_cnt = 0, en_tick = 0, rsp_tick = 0, g3 = 0, last_id = 0, core_cnt = 0;
  bit prev_ready, prev_done, first_after_rst, core_hang;
  digest_t last_dig, rsp_dig [4];
  block_t cur_blk, core_blk, abc_blk, empty_blk;
  int gq [$];
  task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  function automatic digest_t sha1(input block_t b);
    logic [31:0] w [80];
    logic [31:0] a, bb, c, d, e, f, k, t;
    digest_t r;
    for (int i = 0; i < 16; i++) w[i] = b[i];
    for (int i = 16; i < 80; i++) begin
      t = w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16];
      w[i] = {t[30:0], t[31]};
    end
    {a, bb, c, d, e} = {SHA1_H_INIT[0], SHA1_H_INIT[1], SHA1_H_INIT[2], SHA1_H_INIT[3], SHA1_H_INIT[4]};
    for (int i = 0; i < 80; i++) begin
      if (i < 20) begin f = (bb & c) | (~bb & d); k = 32'h5a827999; end
      else if (i < 40) begin f = bb ^ c ^ d; k = 32'h6ed9eba1; end
      else if (i < 60) begin f = (bb & c) | (bb & d) | (c & d); k = 32'h8f1bbcdc; end
      else begin f = bb ^ c ^ d; k = 32'hca62c1d6; end
      t = {a[26:0], a[31:27]} + f + e + k + w[i];
      e = d; d = c; c = {bb[1:0], bb[31:2]}; bb = a; a = t;
    end
    r[0] = SHA1_H_INIT[0] + a; r[1] = SHA1_H_INIT[1] + bb; r[2] = SHA1_H_INIT[2] + c;
    r[3] = SHA1_H_INIT[3] + d; r[4] = SHA1_H_INIT[4] + e;
    return r;
  endfunction
  function automatic block_t rand_blk();
    block_t b;
    for (int i = 0; i < 16; i++) b[i] = $urandom;
    return b;
  endfunction
  function automatic int rr(input int last, input logic [3:0] v);
    for (int k = 1; k <= 4; k++) if (v[(last + k) % 4]) return (last + k) % 4;
    return -1;
  endfunction
  // unresettable core: starts on enable, finishes 81..82 cycles later with the true digest
  initial begin
    core_done = 1'b0;
    core_result = '0;
    forever begin
      @(posedge clk);
      #1;
      core_done = 1'b0;
      if (core_cnt > 0) begin
        core_cnt--;
        if (core_cnt == 0 && !core_hang) begin
          core_done = 1'b1;
          core_result = sha1(core_blk);
        end
      end
      if (core_enable) begin
        core_blk = core_data;
        core_cnt = $urandom_range(SHA1_CORE_LATENCY - 1, SHA1_CORE_LATENCY);
      end
    end
  end
  task automatic tick();
    digest_t ed;
    int j;
    @(negedge clk);
    cyc++;
    since_rst++;
    if (prev_ready) chk("enable_after_grant", core_enable, 1'b1);
    if (core_enable) begin
      chk("core_data", core_data, cur_blk);
      en_cnt++;
      en_tick = cyc;
    end
    if (prev_done && inflight >= 0) chk("rsp_after_done", rsp_valid, 1'b1);
    if (rsp_valid) begin
      if (inflight < 0) chk("spurious_rsp", rsp_valid, 1'b0);
      else begin
        ed = core_hang ? '0 : sha1(cur_blk);
        chk("rsp_id", rsp_id, inflight);
        chk("rsp_error", rsp_error, core_hang);
        chk("rsp_digest", rsp_digest, ed);
        last_dig = rsp_digest;
        last_id = inflight;
        rsp_dig[inflight] = rsp_digest;
        rsp_tick = cyc;
        inflight = -1;
        nrsp++;
      end
    end
    if (|req_ready) begin
      j = rr(m_last, rv);
      chk("one_job_in_flight", inflight < 0, 1'b1);
      chk("grant", req_ready, j < 0 ? 4'b0 : 4'(1 << j));
      if (first_after_rst) begin
        chk("flush_hold", since_rst >= 91, 1'b1);
        first_after_rst = 1'b0;
      end
      if (j >= 0) begin
        m_last = j;
        inflight = j;
        cur_blk = rd[j];
        gq.push_back(j);
        if (j == 3) g3++;
        if (hold[j]) rd[j] = rand_blk();
        else rv[j] = 1'b0;
      end
    end
    prev_ready = |req_ready;
    prev_done = core_done;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    inflight = -1;
    m_last = 3;
    prev_ready = 1'b0;
    prev_done = 1'b0;
    repeat (2) tick();
    chk("rst_busy", busy, 1'b1);
    chk("rst_req_ready", req_ready, 4'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_id", rsp_id, 2'b0);
    chk("rst_rsp_digest", rsp_digest, '0);
    chk("rst_rsp_error", rsp_error, 1'b0);
    chk("rst_core_enable", core_enable, 1'b0);
    chk("rst_core_data", core_data, '0);
    reset = 1'b0;
    since_rst = 0;
    first_after_rst = 1'b1;
  endtask
  task automatic wait_rsp(input int target, input int budget);
    for (int i = 0; i < budget && nrsp < target; i++) tick();
    chk("wait_rsp", nrsp, target);
  endtask
  task automatic wait_en(input int budget);
    int t;
    t = en_cnt + 1;
    for (int i = 0; i < budget && en_cnt < t; i++) tick();
    chk("wait_enable", en_cnt, t);
  endtask
  initial begin
    #5_000_000;
    $display("FAIL global_timeout");
    $fatal(1);
  end
  initial begin
    int n0, g0;
    reset = 1'b1;
    rv = '0;
    hold = '0;
    core_hang = 1'b0;
    for (int i = 0; i < 4; i++) rd[i] = '0;
    abc_blk = '0;
    abc_blk[0] = 32'h61626380;
    abc_blk[15] = 32'h00000018;
    empty_blk = '0;
    empty_blk[0] = 32'h80000000;
    do_reset();
    rd[0] = abc_blk;
    rv = 4'b0001;
    wait_rsp(1, 400);
    chk("abc_id", last_id, 0);
    chk("abc_digest", last_dig, ABC);
    do_reset();
    gq.delete();
    for (int i = 0; i < 4; i++) rd[i] = rand_blk();
    rd[2] = empty_blk;
    rv = 4'b1111;
    wait_rsp(nrsp + 4, 800);
    chk("order4_len", gq.size(), 4);
    for (int i = 0; i < gq.size() && i < 4; i++) chk("order4", gq[i], i);
    chk("empty_digest", rsp_dig[2], EMPTY);
    gq.delete();
    hold = 4'b0011;
    rd[0] = rand_blk();
    rd[1] = rand_blk();
    rv = 4'b0011;
    wait_rsp(nrsp + 6, 1000);
    hold = '0;
    rv = '0;
    chk("alt_len", gq.size(), 6);
    for (int i = 0; i < gq.size() && i < 6; i++) chk("alternate", gq[i], i % 2);
    rd[0] = abc_blk;
    rv = 4'b0001;
    wait_en(50);
    repeat (40) tick();
    n0 = nrsp;
    do_reset();
    rd[0] = abc_blk;
    rv = 4'b0001;
    wait_rsp(n0 + 1, 400);
    chk("abort_then_abc", last_dig, ABC);
    rd[1] = rand_blk();
    rd[3] = rand_blk();
    rv = 4'b1010;
    wait_en(50);
    repeat (10) tick();
    rv[3] = 1'b0;
    g0 = g3;
    wait_rsp(nrsp + 1, 200);
    repeat (20) tick();
    chk("req3_skipped", g3, g0);
    chk("req3_other_id", last_id, 1);
    for (int it = 0; it < 20; it++) begin
      for (int i = 0; i < 4; i++)
        if (!rv[i] && $urandom_range(0, 1) == 1) begin
          rv[i] = 1'b1;
          rd[i] = rand_blk();
        end
      if (rv == '0) begin
        rv[it % 4] = 1'b1;
        rd[it % 4] = rand_blk();
      end
      wait_rsp(nrsp + 1, 300);
      if ($urandom_range(0, 3) == 0) rv[$urandom_range(0, 3)] = 1'b0;
    end
    rv = '0;
    wait_rsp(nrsp + (inflight >= 0 ? 1 : 0), 300);
`ifdef SHA1_ARB_TIMEOUT_EN
    do_reset();
    core_hang = 1'b1;
    rd[0] = rand_blk();
    rv = 4'b0001;
    wait_rsp(nrsp + 1, 500);
    chk("timeout_latency", rsp_tick - en_tick, 127);
    tick();
    chk("timeout_flush_busy", busy, 1'b1);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sha_1_arbiter.md
SHA_1_ARBITER -- requirements
Module: sha_1_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one sha_1_core, range 2..8.
REQ-002 Parameter TIMEOUT_CYCLES, default 127: WAIT-state watchdog limit in cycles; used only when SHA1_ARB_TIMEOUT_EN is defined.
REQ-003 clk  input  1  rising-edge clock shared with sha_1_core.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  NUM_REQ  requester i holds a block for hashing.
REQ-006 req_data  input  NUM_REQ x 16 x 32  padded 512-bit block per requester; word 0 first.
REQ-007 req_ready  output  NUM_REQ  one-hot, one-cycle accept pulse.
REQ-008 rsp_valid  output  1  one-cycle digest-valid pulse.
REQ-009 rsp_id  output  clog2(NUM_REQ)  index of the requester owning the response.
REQ-010 rsp_digest  output  5 x 32  digest H0..H4.
REQ-011 rsp_error  output  1  response is a timeout abort; qualified by rsp_valid.
REQ-012 core_enable  output  1  start pulse to sha_1_core.enable.
REQ-013 core_data  output  16 x 32  block to sha_1_core.data.
REQ-014 core_result  input  5 x 32  from sha_1_core.q_result.
REQ-015 core_done  input  1  from sha_1_core.q_done.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 FSM states SHALL be FLUSH, IDLE, LOAD, WAIT and RESP.
REQ-018 IDLE: when any req_valid is high, grant the first set bit searching round-robin from (last_grant+1) mod NUM_REQ, pulse req_ready for that requester, latch its req_data and index, update last_grant, then go to LOAD.
REQ-019 Requesters SHALL hold req_valid and req_data until req_ready is seen; data is sampled only in the req_ready cycle.
REQ-020 LOAD: core_enable high for exactly one cycle with core_data set to the latched block, then go to WAIT.
REQ-021 core_data SHALL stay stable from LOAD until the next grant.
REQ-022 WAIT: on core_done high, register core_result into rsp_digest and go to RESP.
REQ-023 RESP: rsp_valid high for one cycle with rsp_id and rsp_error=0, then go to IDLE.
REQ-024 No grant SHALL occur outside IDLE, so at most one job is in flight.
REQ-025 Latency: req_ready at cycle T gives core_enable at T+1; rsp_valid follows core_done by one cycle (core_done nominally arrives 81 to 82 cycles after core_enable).
REQ-026 core_done seen in any state other than WAIT SHALL be ignored.
REQ-027 FLUSH: a FLUSH_CYCLES down-counter runs with req_ready=0 and core_enable=0, then goes to IDLE; this drains any job the unresettable core still has in progress.
REQ-028 A requester that drops req_valid before its grant is skipped without error.

Reset
REQ-029 reset SHALL force state=FLUSH, flush counter=FLUSH_CYCLES, last_grant=NUM_REQ-1 (so requester 0 is checked first), and all of the following to zero: req_ready, rsp_valid, rsp_id, rsp_digest, rsp_error, core_enable, core_data. busy SHALL be 1.
REQ-030 Reset asserted mid-job (LOAD, WAIT or RESP) SHALL abort the job without any rsp_valid; the stale core_done that follows SHALL be absorbed by FLUSH.

Configuration
REQ-031 With SHA1_ARB_TIMEOUT_EN defined: WAIT counts cycles; on reaching TIMEOUT_CYCLES without core_done, rsp_valid=1, rsp_error=1, rsp_digest=0, then go to FLUSH instead of IDLE.
REQ-032 With SHA1_ARB_TIMEOUT_EN undefined: no watchdog, WAIT is unbounded, and rsp_error is tied to 0.

Structure
REQ-033 Package sha_1_pkg SHALL hold: the block and digest typedefs (16x32, 5x32), the arbiter state enum, SHA1_CORE_LATENCY=82, FLUSH_CYCLES=90, and the SHA-1 initial hash constants.
REQ-034 The round-robin grant logic SHALL be a combinational sub-module, sha_1_rr_pick (inputs: request vector and last_grant; outputs: one-hot grant and index).

Verification
REQ-035 "abc" on requester 0 (block 61626380, 13 zero words, 00000018) -> rsp_id=0, digest a9993e36 4706816a ba3e2571 7850c26c 9cd0d89d.
REQ-036 All four requesters valid together after reset, requester 2 carrying the empty-string block (80000000, zeros) -> grant order 0,1,2,3; response for requester 2 has digest da39a3ee 5e6b4b0d 3255bfef 95601890 afd80709.
REQ-037 Requesters 0 and 1 held valid continuously for 6 jobs -> grants alternate 0,1,0,1,0,1 with no starvation.
REQ-038 reset pulsed 40 cycles into WAIT -> no rsp_valid; req_ready stays low for 90 cycles; the stale core_done is ignored; the next "abc" job returns the correct digest.
REQ-039 With SHA1_ARB_TIMEOUT_EN, core model never asserts done -> 127 cycles after entering WAIT, rsp_valid=1, rsp_error=1, digest 0, then FLUSH.
REQ-040 req_valid on requester 3 deasserted during another requester's WAIT -> requester 3 never granted, no response issued for it.
